// File: rtl/bcd_seq_adder.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// behind a start valid/ready handshake with a held result until out_ready.
module bcd_seq_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [W-1:0]    r_a, r_b, r_acc, r_sum;
  logic            r_sub, r_carry, r_err_acc, r_cout, r_err;
  logic [CntW-1:0] r_cnt;

  logic            w_accept, w_last, w_gt9, w_dig_err;
  logic [3:0]      w_a_dig, w_b_dig, w_b_eff, w_digit;
  logic [4:0]      w_t;
  logic [W-1:0]    w_acc_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start_valid)      w_state_next = StRun;
      StRun:   if (r_cnt == LastCnt) w_state_next = StDone;
      StDone:  if (out_ready)        w_state_next = StIdle;
      default:                       w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    start_ready = (r_state == StIdle) && !rst;
    out_valid   = (r_state == StDone);
  end

  assign w_accept = start_valid && start_ready;
  assign w_last   = (r_state == StRun) && (r_cnt == LastCnt);

  // Subtraction uses the 9's complement of B with the inverted borrow as initial carry
  assign w_a_dig    = r_a[3:0];
  assign w_b_dig    = r_b[3:0];
  assign w_b_eff    = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
  assign w_t        = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {4'b0, r_carry};
  assign w_gt9      = (w_t > 5'd9);
  assign w_digit    = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
  assign w_dig_err  = (w_a_dig > 4'd9) || (w_b_dig > 4'd9);
  assign w_acc_next = (r_acc >> 4) | (W'(w_digit) << (W - 4));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_sub     <= 1'b0;
      r_carry   <= 1'b0;
      r_err_acc <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_sub     <= sub;
      r_carry   <= sub ? ~cin : cin;
      r_err_acc <= 1'b0;
      r_cnt     <= '0;
    end else if (r_state == StRun) begin
      r_a       <= r_a >> 4;
      r_b       <= r_b >> 4;
      r_carry   <= w_gt9;
      r_err_acc <= r_err_acc | w_dig_err;
      r_cnt     <= r_cnt + CntW'(1);
      r_acc     <= w_acc_next;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_gt9;
        r_err  <= r_err_acc | w_dig_err;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign err  = r_err;

endmodule
